// File: rtl/memory_arbiter_if.sv
// RAM-side bus shared by the arbiter (master modport) and the on-chip RAM (slave modport).
interface MemoryInterface #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 16
);
  logic [ADDRESS_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0]    dataOut;
  logic [DATA_WIDTH-1:0]    dataIn;
  logic                     readEnabled;
  logic                     writeEnabled;
  logic                     functionComplete;

  modport master (
    output address, dataOut, readEnabled, writeEnabled,
    input  dataIn, functionComplete
  );

  modport slave (
    input  address, dataOut, readEnabled, writeEnabled,
    output dataIn, functionComplete
  );
endinterface

// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing one RAM among NUMBER_OF_MASTERS requesters, with a release slot after each transfer.
// Optional `MEMORY_ARBITER_LOCK_EN adds a per-master lock input that keeps the grant across back-to-back transfers.
module memory_arbiter #(
  parameter int ADDRESS_WIDTH     = 16,
  parameter int DATA_WIDTH        = 16,
  parameter int NUMBER_OF_MASTERS = 4,
  parameter int MASTER_WIDTH      = $clog2(NUMBER_OF_MASTERS)
) (
  input  logic                                             clock,
  input  logic                                             reset,
  input  logic [NUMBER_OF_MASTERS-1:0]                     request,
`ifdef MEMORY_ARBITER_LOCK_EN
  input  logic [NUMBER_OF_MASTERS-1:0]                     lock,
`endif
  output logic [NUMBER_OF_MASTERS-1:0]                     grant,
  input  logic [NUMBER_OF_MASTERS-1:0][ADDRESS_WIDTH-1:0]  masterAddress,
  input  logic [NUMBER_OF_MASTERS-1:0][DATA_WIDTH-1:0]     masterDataOut,
  input  logic [NUMBER_OF_MASTERS-1:0]                     masterReadEnabled,
  input  logic [NUMBER_OF_MASTERS-1:0]                     masterWriteEnabled,
  output logic [DATA_WIDTH-1:0]                            masterDataIn,
  output logic [NUMBER_OF_MASTERS-1:0]                     masterFunctionComplete,
  MemoryInterface.master                                   memoryInterface
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANTED = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t                         r_state;
  state_t                         w_next_state;
  logic [MASTER_WIDTH-1:0]        r_grant_index;
  logic [MASTER_WIDTH-1:0]        w_next_grant_index;
  logic [MASTER_WIDTH-1:0]        r_pointer;
  logic [MASTER_WIDTH-1:0]        w_next_pointer;
  logic [NUMBER_OF_MASTERS-1:0]   r_grant;
  logic [NUMBER_OF_MASTERS-1:0]   w_next_grant;

  logic                           w_pick_found;
  logic [MASTER_WIDTH-1:0]        w_pick_index;
  logic [MASTER_WIDTH-1:0]        w_index_inc;
  logic                           w_sel_request;
  logic                           w_sel_active;
  logic                           w_done;
  logic                           w_lock_hold;

  logic [ADDRESS_WIDTH-1:0]       w_mem_address;
  logic [DATA_WIDTH-1:0]          w_mem_data;
  logic                           w_mem_read;
  logic                           w_mem_write;

  assign w_sel_request = request[r_grant_index];
  assign w_sel_active  = masterReadEnabled[r_grant_index] | masterWriteEnabled[r_grant_index];
  assign w_done        = memoryInterface.functionComplete & w_sel_active;
  assign w_index_inc   = (r_grant_index == MASTER_WIDTH'(NUMBER_OF_MASTERS - 1))
                         ? '0 : (r_grant_index + MASTER_WIDTH'(1));

`ifdef MEMORY_ARBITER_LOCK_EN
  assign w_lock_hold = lock[r_grant_index] & request[r_grant_index];
`else
  assign w_lock_hold = 1'b0;
`endif

  // Round-robin pick: scan from the highest offset down so the nearest requester at/after pointer wins.
  always_comb begin
    logic [MASTER_WIDTH:0]   v_sum;
    logic [MASTER_WIDTH-1:0] v_idx;
    w_pick_found = 1'b0;
    w_pick_index = '0;
    for (int off = NUMBER_OF_MASTERS - 1; off >= 0; off--) begin
      v_sum = {1'b0, r_pointer} + (MASTER_WIDTH+1)'(off);
      v_idx = (v_sum >= (MASTER_WIDTH+1)'(NUMBER_OF_MASTERS))
              ? MASTER_WIDTH'(v_sum - (MASTER_WIDTH+1)'(NUMBER_OF_MASTERS))
              : MASTER_WIDTH'(v_sum);
      w_pick_found = w_pick_found | request[v_idx];
      w_pick_index = request[v_idx] ? v_idx : w_pick_index;
    end
  end

  // State register and arbitration bookkeeping.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_grant_index <= '0;
      r_pointer     <= '0;
      r_grant       <= '0;
    end else begin
      r_state       <= w_next_state;
      r_grant_index <= w_next_grant_index;
      r_pointer     <= w_next_pointer;
      r_grant       <= w_next_grant;
    end
  end

  // Next-state, next-pointer and next-grant decode.
  always_comb begin
    w_next_state       = r_state;
    w_next_grant_index = r_grant_index;
    w_next_pointer     = r_pointer;
    case (r_state)
      IDLE: begin
        if (w_pick_found) begin
          w_next_state       = GRANTED;
          w_next_grant_index = w_pick_index;
        end else begin
          w_next_state       = IDLE;
        end
      end
      GRANTED: begin
        if (w_done) begin
          w_next_state = RELEASE;
        end else if (!w_sel_request && !w_sel_active) begin
          w_next_state   = IDLE;
          w_next_pointer = w_index_inc;
        end else begin
          w_next_state = GRANTED;
        end
      end
      RELEASE: begin
        if (w_lock_hold) begin
          w_next_state = GRANTED;
        end else begin
          w_next_state   = IDLE;
          w_next_pointer = w_index_inc;
        end
      end
      default: begin
        w_next_state       = IDLE;
        w_next_grant_index = '0;
        w_next_pointer     = '0;
      end
    endcase

    // A locked master keeps its grant visible through the release slot.
    w_next_grant = '0;
    if ((w_next_state == GRANTED) || ((w_next_state == RELEASE) && w_lock_hold)) begin
      w_next_grant[w_next_grant_index] = 1'b1;
    end else begin
      w_next_grant = '0;
    end
  end

  // RAM-side mux and completion routing; everything idles at zero outside GRANTED.
  always_comb begin
    w_mem_address          = '0;
    w_mem_data             = '0;
    w_mem_read             = 1'b0;
    w_mem_write            = 1'b0;
    masterFunctionComplete = '0;
    if (r_state == GRANTED) begin
      w_mem_address                         = masterAddress[r_grant_index];
      w_mem_data                            = masterDataOut[r_grant_index];
      w_mem_read                            = masterReadEnabled[r_grant_index];
      w_mem_write                           = masterWriteEnabled[r_grant_index];
      masterFunctionComplete[r_grant_index] = w_done;
    end else begin
      masterFunctionComplete = '0;
    end
  end

  assign grant                        = r_grant;
  assign masterDataIn                 = memoryInterface.dataIn;
  assign memoryInterface.address      = w_mem_address;
  assign memoryInterface.dataOut      = w_mem_data;
  assign memoryInterface.readEnabled  = w_mem_read;
  assign memoryInterface.writeEnabled = w_mem_write;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter with a behavioural DELAY-cycle RAM; lock scenario runs when MEMORY_ARBITER_LOCK_EN is defined.
module tb_memory_arbiter;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int NM = 4;
  localparam int DELAY = 4;
  localparam int RAM_WORDS = 64;

  logic                    clock = 1'b0;
  logic                    reset = 1'b0;
  logic [NM-1:0]           request = '0;
  logic [NM-1:0]           grant;
  logic [NM-1:0][AW-1:0]   m_addr = '0;
  logic [NM-1:0][DW-1:0]   m_dout = '0;
  logic [NM-1:0]           m_re = '0;
  logic [NM-1:0]           m_we = '0;
  logic [DW-1:0]           m_din;
  logic [NM-1:0]           m_fc;
`ifdef MEMORY_ARBITER_LOCK_EN
  logic [NM-1:0]           lock = '0;
`endif

  int vectors = 0;
  int miscompares = 0;
  int n;

  MemoryInterface #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) mem_if ();

  memory_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .NUMBER_OF_MASTERS(NM)) dut (
    .clock                  (clock),
    .reset                  (reset),
    .request                (request),
`ifdef MEMORY_ARBITER_LOCK_EN
    .lock                   (lock),
`endif
    .grant                  (grant),
    .masterAddress          (m_addr),
    .masterDataOut          (m_dout),
    .masterReadEnabled      (m_re),
    .masterWriteEnabled     (m_we),
    .masterDataIn           (m_din),
    .masterFunctionComplete (m_fc),
    .memoryInterface        (mem_if)
  );

  always #5 clock = ~clock;

  // Behavioural RAM: completes once the enable has been held DELAY cycles; reloads when enables drop.
  logic [DW-1:0] ram [0:RAM_WORDS-1];
  int            ram_cnt;
  wire ram_en    = mem_if.readEnabled | mem_if.writeEnabled;
  wire ram_range = (mem_if.address < 16'(RAM_WORDS));
  assign mem_if.functionComplete = ram_en && ram_range && (ram_cnt == DELAY);
  assign mem_if.dataIn = (mem_if.readEnabled && ram_range) ? ram[mem_if.address[5:0]] : 16'h0000;

  always @(posedge clock or negedge reset) begin
    if (!reset)               ram_cnt <= 0;
    else if (!ram_en)         ram_cnt <= 0;
    else if (ram_cnt < DELAY) ram_cnt <= ram_cnt + 1;
  end

  always @(posedge clock) begin
    if (mem_if.functionComplete && mem_if.writeEnabled) ram[mem_if.address[5:0]] <= mem_if.dataOut;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_grant(output int cnt);
    cnt = 0;
    do begin
      @(negedge clock);
      cnt++;
    end while (grant == '0 && cnt < 10);
  endtask

  task automatic wait_done(output int cnt);
    cnt = 0;
    while (m_fc == '0 && cnt < 20) begin
      @(negedge clock);
      cnt++;
    end
  endtask

  initial begin
    int order [5] = '{0, 2, 3, 0, 2};
    logic [NM-1:0] exp_g;

    // Reset values
    #2;
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_re", 32'(mem_if.readEnabled), 32'h0);
    check("rst_we", 32'(mem_if.writeEnabled), 32'h0);
    check("rst_addr", 32'(mem_if.address), 32'h0);
    check("rst_fc", 32'(m_fc), 32'h0);

    // Master 1 writes 0xBEEF to address 5, then reads it back
    @(negedge clock);
    reset = 1'b1;
    request[1] = 1'b1; m_we[1] = 1'b1; m_addr[1] = 16'd5; m_dout[1] = 16'hBEEF;
    wait_grant(n);
    check("wr_grant_lat", 32'(n), 32'd1);
    check("wr_grant", 32'(grant), 32'h2);
    check("wr_we_ram", 32'(mem_if.writeEnabled), 32'h1);
    check("wr_addr_ram", 32'(mem_if.address), 32'h5);
    check("wr_fc_early", 32'(m_fc), 32'h0);
    wait_done(n);
    check("wr_done_lat", 32'(n), 32'd4);
    check("wr_fc", 32'(m_fc), 32'h2);
    @(negedge clock);
    check("rel_grant", 32'(grant), 32'h0);
    check("rel_we", 32'(mem_if.writeEnabled), 32'h0);
    request[1] = 1'b0; m_we[1] = 1'b0;
    @(negedge clock);
    check("idle_grant", 32'(grant), 32'h0);
    request[1] = 1'b1; m_re[1] = 1'b1;
    wait_grant(n);
    check("rd_grant", 32'(grant), 32'h2);
    check("rd_re_ram", 32'(mem_if.readEnabled), 32'h1);
    wait_done(n);
    check("rd_done_lat", 32'(n), 32'd4);
    check("rd_data", 32'(m_din), 32'hBEEF);
    @(negedge clock);
    request[1] = 1'b0; m_re[1] = 1'b0;

    // Masters 0, 2, 3 request continuously from reset
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    request = 4'b1101; m_re = 4'b1101;
    m_addr[0] = 16'd10; m_addr[2] = 16'd20; m_addr[3] = 16'd30;
    for (int k = 0; k < 5; k++) begin
      wait_grant(n);
      check($sformatf("rr_gap_%0d", k), 32'(n), (k == 0) ? 32'd1 : 32'd3);
      exp_g = 4'b0001 << order[k];
      check($sformatf("rr_grant_%0d", k), 32'(grant), 32'(exp_g));
      wait_done(n);
      check($sformatf("rr_fc_%0d", k), 32'(m_fc), 32'(exp_g));
    end
    @(negedge clock);
    request = 4'b0000; m_re = 4'b0000;

    // Pointer sits at 3: master 3 first, then wrap to master 0
    @(negedge clock);
    request = 4'b1001; m_re = 4'b1001;
    wait_grant(n);
    check("wrap_grant3", 32'(grant), 32'h8);
    wait_done(n);
    wait_grant(n);
    check("wrap_gap", 32'(n), 32'd3);
    check("wrap_grant0", 32'(grant), 32'h1);
    wait_done(n);
    @(negedge clock);
    request = 4'b0000; m_re = 4'b0000;

    // Master 2 granted, withdraws without any enable
    @(negedge clock);
    request[2] = 1'b1;
    wait_grant(n);
    check("wd_grant", 32'(grant), 32'h4);
    check("wd_fc0", 32'(m_fc), 32'h0);
    request[2] = 1'b0;
    @(negedge clock);
    check("wd_idle_grant", 32'(grant), 32'h0);
    check("wd_fc1", 32'(m_fc), 32'h0);
    @(negedge clock);
    check("wd_stay_idle", 32'(grant), 32'h0);

    // Reset during a master-0 read at its 2nd wait cycle (pointer was 3 beforehand)
    request[0] = 1'b1; m_re[0] = 1'b1; m_addr[0] = 16'd5;
    wait_grant(n);
    check("mr_grant", 32'(grant), 32'h1);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("mr_grant_rst", 32'(grant), 32'h0);
    check("mr_re_rst", 32'(mem_if.readEnabled), 32'h0);
    check("mr_addr_rst", 32'(mem_if.address), 32'h0);
    check("mr_fc_rst", 32'(m_fc), 32'h0);
    request = 4'b0000; m_re = 4'b0000;
    @(negedge clock);
    reset = 1'b1;
    request = 4'b1010; m_re = 4'b1010; m_addr[1] = 16'd7; m_addr[3] = 16'd9;
    wait_grant(n);
    check("mr_after_grant", 32'(grant), 32'h2);
    @(negedge clock);
    request = 4'b0000; m_re = 4'b0000;

`ifdef MEMORY_ARBITER_LOCK_EN
    // Master 0 locks for read-modify-write while master 1 waits
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    lock[0] = 1'b1; request = 4'b0011; m_re = 4'b0011;
    m_addr[0] = 16'd5; m_addr[1] = 16'd6;
    wait_grant(n);
    check("lk_grant", 32'(grant), 32'h1);
    wait_done(n);
    check("lk_rd_done", 32'(n), 32'd4);
    @(negedge clock);
    check("lk_rel_grant", 32'(grant), 32'h1);
    check("lk_rel_re", 32'(mem_if.readEnabled), 32'h0);
    m_re[0] = 1'b0; m_we[0] = 1'b1; m_dout[0] = 16'h1234;
    @(negedge clock);
    check("lk_regrant", 32'(grant), 32'h1);
    check("lk_we_ram", 32'(mem_if.writeEnabled), 32'h1);
    lock[0] = 1'b0;
    wait_done(n);
    check("lk_wr_done", 32'(n), 32'd4);
    @(negedge clock);
    check("lk_unlock_grant", 32'(grant), 32'h0);
    request[0] = 1'b0; m_we[0] = 1'b0;
    wait_grant(n);
    check("lk_m1_lat", 32'(n), 32'd2);
    check("lk_m1_grant", 32'(grant), 32'h2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Round-robin arbiter that shares one `MemoryInterface` slave (the on-chip RAM) between `NUMBER_OF_MASTERS` requesters. It sits between the CPU/DMA/peripheral bus masters and the RAM. It grants one master at a time, muxes that master's address, data and enables onto the RAM, and routes `functionComplete` back to that master only. It inserts a one-cycle release slot after every transfer so the RAM's delay counter reloads before the next master starts.

## Interface
Parameters:
- `ADDRESS_WIDTH`, default 16: address width.
- `DATA_WIDTH`, default 16: word width.
- `NUMBER_OF_MASTERS`, default 4: number of requesters; must be at least 2.
- `MASTER_WIDTH`, default `$clog2(NUMBER_OF_MASTERS)`: width of the grant index.

Ports:
- `clock`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `request`  in  `[NUMBER_OF_MASTERS]`  master i wants the memory.
- `grant`  out  `[NUMBER_OF_MASTERS]`  one-hot or zero; registered.
- `masterAddress`  in  `[NUMBER_OF_MASTERS][ADDRESS_WIDTH]`  per-master address.
- `masterDataOut`  in  `[NUMBER_OF_MASTERS][DATA_WIDTH]`  per-master write data.
- `masterReadEnabled`, `masterWriteEnabled`  in  `[NUMBER_OF_MASTERS]`  per-master enables.
- `masterDataIn`  out  `DATA_WIDTH`  read data, broadcast to all masters; valid only to the granted master.
- `masterFunctionComplete`  out  `[NUMBER_OF_MASTERS]`  transfer done, granted master only.
- `memoryInterface`  `MemoryInterface.master`  to RAM: `address`, `dataOut`, `readEnabled`, `writeEnabled` are outputs; `dataIn` and `functionComplete` are inputs.

## Operation
- States: `IDLE`, `GRANTED`, `RELEASE`. Registered state: `grantIndex`, `pointer` (next master to get priority).
- `IDLE`:
  - `grant = 0`; RAM enables are 0.
  - If any `request` is high, pick the first requesting index at or after `pointer`, searching modulo N.
  - Load `grantIndex`, set `grant[grantIndex]`, and go to `GRANTED`.
- `GRANTED`:
  - RAM `address`, `dataOut`, `readEnabled` and `writeEnabled` are driven combinationally from master `grantIndex`.
  - `masterFunctionComplete[grantIndex] = memoryInterface.functionComplete & (read | write enable of that master)`. All other bits are 0.
  - When the RAM reports complete with an enable high, go to `RELEASE`.
  - If the master drops `request` with both enables low, go to `IDLE`, clear `grant`, and set `pointer <= grantIndex+1`.
- `RELEASE`:
  - RAM enables are forced to 0 and `grant` is cleared.
  - Set `pointer <= grantIndex+1` modulo N, wrapping from N-1 to 0.
  - Go to `IDLE`.
- A granted master that raises both enables gets a write; the RAM gives write priority.
- A master keeps its enable and address stable from assertion until it sees its `masterFunctionComplete`.
- A master with `request` low never receives a grant.
- An address at or beyond the RAM size never completes. The arbiter holds the grant until the master withdraws (without the lock feature, no timeout exists).

## Timing
- Reset values: state `IDLE`, `grant = 0`, `grantIndex = 0`, `pointer = 0`. All RAM-side enables are 0, and `address`/`dataOut` are 0 while not granted. `masterFunctionComplete` is 0.
- Request sampled at edge k gives `grant` high after edge k (cycle k+1). The master's enable can reach the RAM in that same cycle.
- The RAM completes after DELAY cycles of held enable. The complete cycle is followed by one `RELEASE` cycle and one `IDLE` cycle.
- Minimum master-to-master turnaround: 2 cycles after the complete cycle.
- Reset asserted mid-transfer: everything returns immediately, asynchronously, to reset values. The interrupted RAM write may or may not have landed; this is not defined.

## Configuration
- `MEMORY_ARBITER_LOCK_EN` defined:
  - Adds input `lock [NUMBER_OF_MASTERS]`.
  - In `RELEASE`, if `lock[grantIndex]` and `request[grantIndex]` are high, the next state is `GRANTED` with the same grant. `grant` stays high, `pointer` is unchanged, and enables are still forced low for that one cycle.
  - This allows atomic read-modify-write sequences.
- Undefined: no `lock` port, and `RELEASE` always goes to `IDLE`.

## Test plan
- DELAY=4, master 1 alone writes 0xBEEF to address 5, then reads it back:
  - `grant` = 4'b0010 one cycle after the request.
  - Complete arrives 4 cycles after the enable.
  - Read returns 0xBEEF on `masterDataIn`.
- Masters 0, 2 and 3 request continuously from reset, each doing one read per grant:
  - Grant order is 0, 2, 3, 0, 2.
  - `grant` is never more than one-hot.
  - Exactly 2 idle cycles occur between completes.
- Master 3 granted and pointer wraps: the next grant goes to master 0 when masters 0 and 3 both request.
- Master 2 granted, drops `request` with no enable: returns to `IDLE` and no `masterFunctionComplete` pulses.
- Reset pulled low during a master-0 read at its 2nd wait cycle:
  - `grant`, enables and pointer read 0 immediately.
  - After release, master 1 requesting is granted first.
- With `MEMORY_ARBITER_LOCK_EN`, master 0 locks while master 1 requests:
  - Master 0 does read then write with no `IDLE` cycle between.
  - Master 1 is granted after master 0 drops `lock`.
